// File: rtl/axi_lite_gpio_slave.sv
// rtl/axi_lite_gpio_slave.sv - AXI4-Lite GPIO register slave with input-change interrupt
//
// Purpose: terminates an AXI4-Lite bus and exposes four 32-bit registers:
//   0x0 DATA (read: per bit tri ? synced pin : output latch), 0x4 TRI,
//   0x8 IER (bit0 global enable, bit1 change enable), 0xC ISR (bit0 pending, W1C).
//   Offsets at or above 0x10 answer SLVERR, are not written and read as zero.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   s_axi_aw*/w*/b*       write address, write data and write response channels
//   s_axi_ar*/r*          read address and read data channels
//   gpio_i                asynchronous pin inputs
//   gpio_o, gpio_t        output data and tri-state enables (1 = high-Z / input)
//   irq                   registered level interrupt
module axi_lite_gpio_slave #(
    parameter int          C_S_AXI_ADDR_WIDTH = 9,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_GPIO_WIDTH       = 32,
    parameter logic [31:0] C_DOUT_DEFAULT     = 32'h0,
    parameter logic [31:0] C_TRI_DEFAULT      = 32'hFFFF_FFFF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    input  logic [C_GPIO_WIDTH-1:0]           gpio_i,
    output logic [C_GPIO_WIDTH-1:0]           gpio_o,
    output logic [C_GPIO_WIDTH-1:0]           gpio_t,
    output logic                              irq
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int GW = C_GPIO_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic            aw_held, w_held;
    logic [AW-1:0]   awaddr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;

    logic [GW-1:0]   dout, tri_reg;
    logic [GW-1:0]   sync1, sync2, prev;
    logic [1:0]      ier;
    logic            isr;

    logic aw_hs, w_hs, ar_hs;
    logic do_write, wr_ok, rd_ok;
    logic [DW-1:0] wr_old, wr_merged, rd_val;
    logic isr_clear, gpio_change;
    logic unused_addr_bits;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // The register update happens the cycle after both halves are held.
    assign do_write = (w_state == W_IDLE) & aw_held & w_held;
    assign wr_ok    = (awaddr_q[AW-1:4] == '0);
    assign rd_ok    = (s_axi_araddr[AW-1:4] == '0);

    // Byte-lane addresses are ignored; accesses are word-wide.
    assign unused_addr_bits = ^{awaddr_q[1:0], s_axi_araddr[1:0]};

    assign gpio_o = dout;
    assign gpio_t = tri_reg;

    // ---------------------------------------------------------------- FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_held && w_held) w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready)      w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)        r_state_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // ------------------------------------------------------- write channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // Ready rises on the first idle cycle and stays up until its own handshake.
                    if (aw_hs) begin
                        aw_held       <= 1'b1;
                        awaddr_q      <= s_axi_awaddr;
                        s_axi_awready <= 1'b0;
                    end else if (!aw_held) begin
                        s_axi_awready <= 1'b1;
                    end
                    if (w_hs) begin
                        w_held       <= 1'b1;
                        wdata_q      <= s_axi_wdata;
                        wstrb_q      <= s_axi_wstrb;
                        s_axi_wready <= 1'b0;
                    end else if (!w_held) begin
                        s_axi_wready <= 1'b1;
                    end
                    if (aw_held && w_held) begin
                        s_axi_bvalid <= 1'b1;
                        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_bresp   <= RESP_OKAY;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Current contents of the addressed register, then byte-strobe merge.
    always_comb begin
        wr_old = '0;
        case (awaddr_q[3:2])
            2'd0:    wr_old[GW-1:0] = dout;
            2'd1:    wr_old[GW-1:0] = tri_reg;
            2'd2:    wr_old[1:0]    = ier;
            default: wr_old[0]      = isr;
        endcase
        wr_merged = wr_old;
        for (int i = 0; i < DW/8; i++) begin
            if (wstrb_q[i]) wr_merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    assign isr_clear = do_write & wr_ok & (awaddr_q[3:2] == 2'd3) & wstrb_q[0] & wdata_q[0];

    // --------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= C_DOUT_DEFAULT[GW-1:0];
            tri_reg <= C_TRI_DEFAULT[GW-1:0];
            ier     <= 2'b00;
        end else if (do_write && wr_ok) begin
            case (awaddr_q[3:2])
                2'd0:    dout    <= wr_merged[GW-1:0];
                2'd1:    tri_reg <= wr_merged[GW-1:0];
                2'd2:    ier     <= wr_merged[1:0];
                default: ;
            endcase
        end
    end

    // Only pins configured as inputs may raise a change event.
    assign gpio_change = |((sync2 ^ prev) & tri_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            isr   <= 1'b0;
            irq   <= 1'b0;
        end else begin
            sync1 <= gpio_i;
            sync2 <= sync1;
            prev  <= sync2;
            // A fresh change event wins over a simultaneous write-1-to-clear.
            if (gpio_change)
                isr <= 1'b1;
            else if (isr_clear)
                isr <= 1'b0;
            irq <= ier[0] & ier[1] & isr;
        end
    end

    // -------------------------------------------------------- read channel
    always_comb begin
        rd_val = '0;
        case (s_axi_araddr[3:2])
            2'd0:    rd_val[GW-1:0] = (tri_reg & sync2) | (~tri_reg & dout);
            2'd1:    rd_val[GW-1:0] = tri_reg;
            2'd2:    rd_val[1:0]    = ier;
            default: rd_val[0]      = isr;
        endcase
        if (!rd_ok) rd_val = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= rd_val;
                        s_axi_rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_gpio_slave.sv
// tb/tb_axi_lite_gpio_slave.sv - randomized self-checking bench for axi_lite_gpio_slave
module tb_axi_lite_gpio_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [8:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_t;
    logic        irq;

    always #5 clk = ~clk;

    axi_lite_gpio_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_dout, m_tri, m_ier, gpio_val;
    logic        m_isr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic model_irq();
        return m_ier[0] & m_ier[1] & m_isr;
    endfunction

    task automatic model_reset();
        m_dout = 32'h0;
        m_tri  = 32'hFFFF_FFFF;
        m_ier  = 32'h0;
        m_isr  = 1'b0;
    endtask

    task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        resp = 2'b00;
        if (a[8:4] != 5'd0) begin
            resp = 2'b10;
        end else begin
            case (a[3:2])
                2'd0: m_dout = merge(m_dout, d, s);
                2'd1: m_tri  = merge(m_tri, d, s);
                2'd2: m_ier  = merge(m_ier, d, s) & 32'h3;
                2'd3: if (s[0] && d[0]) m_isr = 1'b0;
            endcase
        end
    endtask

    task automatic model_read(input logic [8:0] a, output logic [31:0] d, output logic [1:0] resp);
        d    = 32'h0;
        resp = 2'b00;
        if (a[8:4] != 5'd0) begin
            resp = 2'b10;
        end else begin
            case (a[3:2])
                2'd0: d = (m_tri & gpio_val) | (~m_tri & m_dout);
                2'd1: d = m_tri;
                2'd2: d = m_ier;
                2'd3: d = {31'h0, m_isr};
            endcase
        end
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int t = 0;
        logic [1:0] r0;
        resp = 2'b00;
        while (!(aw_done && w_done) && t < 50) begin
            @(negedge clk);
            s_axi_awaddr  = addr;
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            s_axi_awvalid = !aw_done && (t >= aw_dly);
            s_axi_wvalid  = !w_done && (t >= w_dly);
            if (aw_done && !w_done) chk("awready_low_after_aw", s_axi_awready, 0);
            if (w_done && !aw_done) chk("wready_low_after_w", s_axi_wready, 0);
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1;
            t++;
        end
        if (!(aw_done && w_done)) begin
            chk("write_handshake_timeout", 0, 1);
            s_axi_awvalid = 0;
            s_axi_wvalid  = 0;
            return;
        end
        @(negedge clk);
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        chk("bvalid_not_early", s_axi_bvalid, 0);
        @(negedge clk);
        chk("bvalid_latency", s_axi_bvalid, 1);
        r0   = s_axi_bresp;
        resp = r0;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            chk("bvalid_held", s_axi_bvalid, 1);
            chk("bresp_stable", s_axi_bresp, r0);
        end
        s_axi_bready = 1;
        @(negedge clk);
        s_axi_bready = 0;
        chk("bvalid_cleared", s_axi_bvalid, 0);
        chk("awready_restored", s_axi_awready, 1);
        chk("wready_restored", s_axi_wready, 1);
    endtask

    task automatic axi_read(input logic [8:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int t = 0;
        data = 32'h0;
        resp = 2'b00;
        @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1;
        while (!s_axi_arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!s_axi_arready) begin
            chk("read_arready_timeout", 0, 1);
            s_axi_arvalid = 0;
            return;
        end
        @(negedge clk);
        s_axi_arvalid = 0;
        chk("rvalid_latency", s_axi_rvalid, 1);
        chk("arready_low_in_read", s_axi_arready, 0);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("rvalid_held", s_axi_rvalid, 1);
            chk("rdata_stable", s_axi_rdata, data);
        end
        s_axi_rready = 1;
        @(negedge clk);
        s_axi_rready = 0;
        chk("rvalid_cleared", s_axi_rvalid, 0);
        chk("arready_restored", s_axi_arready, 1);
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        logic [1:0] got, exp;
        axi_write(a, d, s, awd, wd, bd, got);
        model_write(a, d, s, exp);
        chk("bresp", got, exp);
        chk("gpio_o", gpio_o, m_dout);
        chk("gpio_t", gpio_t, m_tri);
        chk("irq_after_write", irq, model_irq());
    endtask

    task automatic do_read(input logic [8:0] a, input int rd_dly);
        logic [31:0] ed, gd;
        logic [1:0]  er, gr;
        model_read(a, ed, er);
        axi_read(a, rd_dly, gd, gr);
        chk("rdata", gd, ed);
        chk("rresp", gr, er);
    endtask

    task automatic gpio_change(input logic [31:0] v);
        @(negedge clk);
        if (((gpio_val ^ v) & m_tri) != 32'h0) m_isr = 1'b1;
        gpio_val = v;
        gpio_i   = v;
        repeat (5) @(negedge clk);
        chk("irq_after_gpio", irq, model_irq());
    endtask

    function automatic logic [8:0] rand_addr();
        logic [8:0] a;
        int k;
        k = $urandom_range(0, 5);
        if (k < 4) a = 9'(k * 4);
        else       a = 9'(16 + 4 * $urandom_range(0, 123));
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd;
        logic [1:0]  gr;
        int          n, op;

        rst = 1;
        s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
        s_axi_bready = 0; s_axi_araddr = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        gpio_i = 0; gpio_val = 0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_awready", s_axi_awready, 0);
        chk("rst_wready", s_axi_wready, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_bresp", s_axi_bresp, 0);
        chk("rst_rresp", s_axi_rresp, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_gpio_o", gpio_o, 32'h0);
        chk("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        rst = 0;
        @(negedge clk);
        chk("post_rst_awready", s_axi_awready, 1);
        chk("post_rst_wready", s_axi_wready, 1);
        chk("post_rst_arready", s_axi_arready, 1);

        // 1) same-cycle AW/W write of DATA
        do_write(9'h000, 32'hA5A5_0F0F, 4'hF, 0, 0, 0);
        chk("t1_gpio_o", gpio_o, 32'hA5A5_0F0F);

        // 2) AW at cycle 0, W at cycle 3
        do_write(9'h004, 32'h0000_FFFF, 4'hF, 0, 3, 0);
        chk("t2_gpio_t", gpio_t, 32'h0000_FFFF);

        // 3) mixed input/output DATA readback
        do_write(9'h000, 32'h1234_0000, 4'hF, 1, 0, 1);
        gpio_change(32'h0000_BEEF);
        axi_read(9'h000, 0, gd, gr);
        chk("t3_rdata", gd, 32'h1234_BEEF);
        chk("t3_rresp", gr, 2'b00);

        // 4) change interrupt on pin 0
        do_write(9'h00C, 32'h1, 4'hF, 0, 0, 0);
        do_write(9'h008, 32'h3, 4'hF, 0, 0, 0);
        @(negedge clk);
        gpio_val = gpio_val ^ 32'h1;
        gpio_i   = gpio_val;
        m_isr    = 1'b1;
        n = 0;
        while (!irq && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_irq_latency", n, 4);
        do_read(9'h00C, 0);
        do_write(9'h00C, 32'h1, 4'hF, 0, 0, 0);
        chk("t4_irq_cleared", irq, 0);

        // 5) single-lane strobe
        do_write(9'h000, 32'h0, 4'hF, 0, 0, 0);
        do_write(9'h000, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0);
        chk("t5_gpio_o", gpio_o, 32'h0000_FF00);

        // 6) out-of-range accesses, slow bready
        axi_read(9'h010, 0, gd, gr);
        chk("t6_rresp", gr, 2'b10);
        chk("t6_rdata", gd, 32'h0);
        do_write(9'h1FC, 32'hFFFF_FFFF, 4'hF, 0, 0, 5);
        chk("t6_gpio_o", gpio_o, 32'h0000_FF00);
        chk("t6_gpio_t", gpio_t, 32'h0000_FFFF);

        // Concurrent read and write of TRI: read sees the pre-write value
        fork
            do_write(9'h004, 32'h00FF_00FF, 4'hF, 0, 0, 0);
            do_read(9'h004, 1);
        join

        // Reset in the middle of a read and a half-captured write
        gpio_change(32'h0);
        @(negedge clk);
        s_axi_araddr = 9'h004; s_axi_arvalid = 1;
        s_axi_awaddr = 9'h000; s_axi_awvalid = 1;
        @(negedge clk);
        s_axi_arvalid = 0; s_axi_awvalid = 0;
        @(negedge clk);
        chk("pre_rst_rvalid", s_axi_rvalid, 1);
        #2 rst = 1;
        #1;
        chk("midrst_rvalid", s_axi_rvalid, 0);
        chk("midrst_awready", s_axi_awready, 0);
        chk("midrst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        model_reset();
        @(negedge clk);
        rst = 0;
        do_write(9'h000, 32'h5A5A_C3C3, 4'hF, 2, 0, 0);
        do_read(9'h000, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op < 4)
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            else if (op < 8)
                do_read(rand_addr(), $urandom_range(0, 2));
            else
                gpio_change($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
